// File: rtl/sr_pulse_driver.sv
// Debounced set/reset front end for a NOR SR latch: two-flop synchronisers,
// per-channel debounce, and registered s/r strobes that are never high together.
// Optional macro SR_HOLD_EN switches s/r from one-cycle strobes to held levels.
module sr_pulse_driver #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set,
   input  logic btn_reset,
   output logic s,
   output logic r,
   output logic set_level,
   output logic reset_level
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             set_s1_q, set_s2_q, reset_s1_q, reset_s2_q;
   logic [CNT_W-1:0] set_cnt_q, set_cnt_d, reset_cnt_q, reset_cnt_d;
   logic             set_stable_q, set_stable_d, reset_stable_q, reset_stable_d;
   logic             s_q, s_d, r_q, r_d;
`ifndef SR_HOLD_EN
   logic             set_stable_dly_q, reset_stable_dly_q;
   logic             set_rise, reset_rise;
`endif

   // Two-flop synchronisers for the raw button inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_s1_q   <= 1'b0;
         set_s2_q   <= 1'b0;
         reset_s1_q <= 1'b0;
         reset_s2_q <= 1'b0;
      end else begin
         set_s1_q   <= btn_set;
         set_s2_q   <= set_s1_q;
         reset_s1_q <= btn_reset;
         reset_s2_q <= reset_s1_q;
      end
   end

   // Set-channel debounce: a new level must persist DB_CYCLES samples.
   always_comb begin
      set_cnt_d    = set_cnt_q;
      set_stable_d = set_stable_q;
      if (set_s2_q == set_stable_q) begin
         set_cnt_d = CNT_ZERO;
      end else if (set_cnt_q == CNT_MAX) begin
         set_stable_d = set_s2_q;
         set_cnt_d    = CNT_ZERO;
      end else begin
         set_cnt_d = set_cnt_q + CNT_ONE;
      end
   end

   // Reset-channel debounce, same rule as the set channel.
   always_comb begin
      reset_cnt_d    = reset_cnt_q;
      reset_stable_d = reset_stable_q;
      if (reset_s2_q == reset_stable_q) begin
         reset_cnt_d = CNT_ZERO;
      end else if (reset_cnt_q == CNT_MAX) begin
         reset_stable_d = reset_s2_q;
         reset_cnt_d    = CNT_ZERO;
      end else begin
         reset_cnt_d = reset_cnt_q + CNT_ONE;
      end
   end

   // Debounce counters and accepted levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_cnt_q      <= CNT_ZERO;
         reset_cnt_q    <= CNT_ZERO;
         set_stable_q   <= 1'b0;
         reset_stable_q <= 1'b0;
      end else begin
         set_cnt_q      <= set_cnt_d;
         reset_cnt_q    <= reset_cnt_d;
         set_stable_q   <= set_stable_d;
         reset_stable_q <= reset_stable_d;
      end
   end

`ifndef SR_HOLD_EN
   // Delayed copies of the accepted levels for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_stable_dly_q   <= 1'b0;
         reset_stable_dly_q <= 1'b0;
      end else begin
         set_stable_dly_q   <= set_stable_q;
         reset_stable_dly_q <= reset_stable_q;
      end
   end

   assign set_rise   = set_stable_q & ~set_stable_dly_q;
   assign reset_rise = reset_stable_q & ~reset_stable_dly_q;

   // Strobe mode: reset wins, and a set edge while reset is held is dropped.
   always_comb begin
      r_d = reset_rise;
      s_d = set_rise & ~reset_rise & ~reset_stable_q;
   end
`else
   // Level mode: outputs follow the debounced levels, reset has priority.
   always_comb begin
      r_d = reset_stable_q;
      s_d = set_stable_q & ~reset_stable_q;
   end
`endif

   // Output register feeding the latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         s_q <= s_d;
         r_q <= r_d;
      end
   end

   assign s           = s_q;
   assign r           = r_q;
   assign set_level   = set_stable_q;
   assign reset_level = reset_stable_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Table-driven bench for sr_pulse_driver with DB_CYCLES=4, CNT_W=3, 10 ns clock;
// expectations are hand-computed per cycle, separate tables for SR_HOLD_EN.
module tb_sr_pulse_driver;

   typedef struct {
      logic bs;
      logic br;
      logic es;
      logic er;
      logic esl;
      logic erl;
   } vec_t;

   logic clk;
   logic rst_n;
   logic btn_set;
   logic btn_reset;
   logic s;
   logic r;
   logic set_level;
   logic reset_level;

   int   checks;
   int   errors;
   vec_t vecs[$];

   sr_pulse_driver #(
      .DB_CYCLES(4),
      .CNT_W    (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_set    (btn_set),
      .btn_reset  (btn_reset),
      .s          (s),
      .r          (r),
      .set_level  (set_level),
      .reset_level(reset_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic bs, input logic br, input logic es, input logic er,
                      input logic esl, input logic erl, input int n);
      vec_t v;
      v.bs = bs; v.br = br; v.es = es; v.er = er; v.esl = esl; v.erl = erl;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0b, expected %0b", name, idx, act, exp);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      btn_set   = 1'b0;
      btn_reset = 1'b0;

`ifndef SR_HOLD_EN
      // clean press, hold 20, release
      add(0,0, 0,0, 0,0, 2);
      add(1,0, 0,0, 0,0, 5);
      add(1,0, 0,0, 1,0, 1);
      add(1,0, 1,0, 1,0, 1);
      add(1,0, 0,0, 1,0, 13);
      add(0,0, 0,0, 1,0, 5);
      add(0,0, 0,0, 0,0, 3);
      // bounce every 2 cycles for 12 cycles, then held high
      for (int k = 0; k < 3; k++) begin
         add(1,0, 0,0, 0,0, 2);
         add(0,0, 0,0, 0,0, 2);
      end
      add(1,0, 0,0, 0,0, 5);
      add(1,0, 0,0, 1,0, 1);
      add(1,0, 1,0, 1,0, 1);
      add(1,0, 0,0, 1,0, 4);
      add(0,0, 0,0, 1,0, 5);
      add(0,0, 0,0, 0,0, 3);
      // simultaneous rise: reset wins
      add(1,1, 0,0, 0,0, 5);
      add(1,1, 0,0, 1,1, 1);
      add(1,1, 0,1, 1,1, 1);
      add(1,1, 0,0, 1,1, 5);
      add(0,0, 0,0, 1,1, 5);
      add(0,0, 0,0, 0,0, 3);
      // set pressed while reset held, then re-press after reset released
      add(0,1, 0,0, 0,0, 5);
      add(0,1, 0,0, 0,1, 1);
      add(0,1, 0,1, 0,1, 1);
      add(0,1, 0,0, 0,1, 2);
      add(1,1, 0,0, 0,1, 5);
      add(1,1, 0,0, 1,1, 5);
      add(1,0, 0,0, 1,1, 5);
      add(1,0, 0,0, 1,0, 1);
      add(0,0, 0,0, 1,0, 5);
      add(0,0, 0,0, 0,0, 2);
      add(1,0, 0,0, 0,0, 5);
      add(1,0, 0,0, 1,0, 1);
      add(1,0, 1,0, 1,0, 1);
      add(1,0, 0,0, 1,0, 3);
`else
      // level mode: s held 10 cycles
      add(0,0, 0,0, 0,0, 2);
      add(1,0, 0,0, 0,0, 5);
      add(1,0, 0,0, 1,0, 1);
      add(1,0, 1,0, 1,0, 4);
      add(0,0, 1,0, 1,0, 5);
      add(0,0, 1,0, 0,0, 1);
      add(0,0, 0,0, 0,0, 2);
      // reset during set hold: s falls and r rises on the same edge
      add(1,0, 0,0, 0,0, 5);
      add(1,0, 0,0, 1,0, 1);
      add(1,0, 1,0, 1,0, 2);
      add(1,1, 1,0, 1,0, 5);
      add(1,1, 1,0, 1,1, 1);
      add(1,1, 0,1, 1,1, 3);
`endif

      #1;
      chk("rst_s", 0, s, 1'b0);
      chk("rst_r", 0, r, 1'b0);
      chk("rst_set_level", 0, set_level, 1'b0);
      chk("rst_reset_level", 0, reset_level, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         btn_set   = vecs[i].bs;
         btn_reset = vecs[i].br;
         @(posedge clk);
         #1;
         chk("s", i, s, vecs[i].es);
         chk("r", i, r, vecs[i].er);
         chk("set_level", i, set_level, vecs[i].esl);
         chk("reset_level", i, reset_level, vecs[i].erl);
         chk("s_and_r", i, s & r, 1'b0);
      end

      // asynchronous reset mid-run with both buttons high
      btn_set   = 1'b1;
      btn_reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_set_level", 0, set_level, 1'b1);
      chk("pre_rst_reset_level", 0, reset_level, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_s", 0, s, 1'b0);
      chk("async_rst_r", 0, r, 1'b0);
      chk("async_rst_set_level", 0, set_level, 1'b0);
      chk("async_rst_reset_level", 0, reset_level, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // debounce restarts from scratch after reset release
      for (int e = 0; e <= 6; e++) begin
         @(posedge clk);
         #1;
         chk("post_rst_set_level", e, set_level, (e >= 5) ? 1'b1 : 1'b0);
         chk("post_rst_reset_level", e, reset_level, (e >= 5) ? 1'b1 : 1'b0);
         chk("post_rst_r", e, r, (e == 6) ? 1'b1 : 1'b0);
         chk("post_rst_s", e, s, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
